// File: rtl/display_scanner.sv
// display_scanner
// ---------------
// Time-multiplexed scan driver for a four-digit seven-segment display.
// A prescaler produces one refresh tick every REFRESH_DIV clocks; on each
// tick the scanner moves to the next digit, places that digit's BCD nibble
// on bin and drives its active-low anode. A whole frame is taken from one
// snapshot of the input, so a frame never mixes two input values.
// Leading-zero blanking, a whole-display blink and the minutes/seconds
// separator dot are applied on the way out.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous, active-high reset
//   digits    four BCD nibbles, [3:0] = digit 0 (rightmost) .. [15:12] = digit 3
//   blank_lz  1 = blank leading zeros on digits 3..1
//   blink     1 = whole display flashes every BLINK_TICKS refresh ticks
//   bin       BCD nibble to the segment decoder (4'hF on a blanked digit)
//   an        anode enables, active-low, an[i] selects digit i
//   dp        separator dot, active-low, lit only while digit 2 is lit
module display_scanner #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_TICKS = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic        blank_lz,
  input  logic        blink,
  output logic [3:0]  bin,
  output logic [3:0]  an,
  output logic        dp
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q,   idx_d;
  logic [15:0]   snap_q,  snap_d;
  logic          phase_q, phase_d;
  logic [BW-1:0] bcnt_q,  bcnt_d;
  logic [3:0]    bin_q,   bin_d;
  logic [3:0]    an_q,    an_d;
  logic          dp_q,    dp_d;

  logic          tick_s;
  logic [15:0]   frame_s;
  logic [3:0]    blank_s;
  logic [3:0]    nib_s;

  // Blank mask for the four digits of a frame; digit 0 is never blanked.
  function automatic logic [3:0] lz_mask(input logic [15:0] f, input logic en);
    logic b3;
    logic b2;
    logic b1;
    b3 = en & (f[15:12] == 4'd0);
    b2 = b3 & (f[11:8] == 4'd0);
    b1 = b2 & (f[7:4] == 4'd0);
    return {b3, b2, b1, 1'b0};
  endfunction

  // Select nibble i out of a 16-bit frame.
  function automatic logic [3:0] pick_nibble(input logic [15:0] f, input logic [1:0] i);
    logic [3:0] n;
    case (i)
      2'd0:    n = f[3:0];
      2'd1:    n = f[7:4];
      2'd2:    n = f[11:8];
      2'd3:    n = f[15:12];
      default: n = 4'd0;
    endcase
    return n;
  endfunction

  // Next-state logic: prescaler, scan index, snapshot, blink phase, outputs.
  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    phase_d = phase_q;
    bcnt_d  = bcnt_q;
    bin_d   = bin_q;
    an_d    = an_q;
    dp_d    = dp_q;

    tick_s  = (presc_q == PRESC_LAST);
    // On the wrap tick the new frame is the live input (which is also what
    // snap is about to load); otherwise the frame is the held snapshot.
    frame_s = (idx_q == 2'd3) ? digits : snap_q;
    blank_s = lz_mask(frame_s, blank_lz);
    nib_s   = pick_nibble(frame_s, idx_q + 2'd1);

    if (tick_s) begin
      presc_d = {PW{1'b0}};
      idx_d   = idx_q + 2'd1;

      if (idx_q == 2'd3) begin
        snap_d = digits;
      end else begin
        snap_d = snap_q;
      end

      if (!blink) begin
        phase_d = 1'b1;
        bcnt_d  = {BW{1'b0}};
      end else if (bcnt_q == BLINK_LAST) begin
        phase_d = ~phase_q;
        bcnt_d  = {BW{1'b0}};
      end else begin
        phase_d = phase_q;
        bcnt_d  = bcnt_q + {{(BW-1){1'b0}}, 1'b1};
      end

      if (blank_s[idx_d]) begin
        bin_d = 4'hF;
      end else begin
        bin_d = nib_s;
      end

      if (blank_s[idx_d] || !phase_d) begin
        an_d = 4'b1111;
      end else begin
        an_d = ~(4'b0001 << idx_d);
      end

      if ((idx_d == 2'd2) && !an_d[2]) begin
        dp_d = 1'b0;
      end else begin
        dp_d = 1'b1;
      end
    end else begin
      presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= {PW{1'b0}};
      idx_q   <= 2'd3;
      snap_q  <= 16'h0000;
      phase_q <= 1'b1;
      bcnt_q  <= {BW{1'b0}};
      bin_q   <= 4'b0000;
      an_q    <= 4'b1111;
      dp_q    <= 1'b1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      phase_q <= phase_d;
      bcnt_q  <= bcnt_d;
      bin_q   <= bin_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
    end
  end

  assign bin = bin_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_display_scanner.sv
// Testbench for display_scanner with REFRESH_DIV=4, BLINK_TICKS=2.
// The stimulus process sets inputs one digit slot at a time and queues the
// hand-computed output expected at the coming refresh tick. A separate
// monitor counts clock edges since reset release, pops and compares at every
// fourth edge, and checks that outputs hold steady on the edges in between.
module tb_display_scanner;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] bin;
    logic       dp;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] digits;
  logic        blank_lz;
  logic        blink;
  logic [3:0]  bin;
  logic [3:0]  an;
  logic        dp;

  exp_t q[$];
  int   total;
  int   bad;

  localparam exp_t RST_EXP = '{an: 4'b1111, bin: 4'h0, dp: 1'b1};

  display_scanner #(
    .REFRESH_DIV(4),
    .BLINK_TICKS(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .digits   (digits),
    .blank_lz (blank_lz),
    .blink    (blink),
    .bin      (bin),
    .an       (an),
    .dp       (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input exp_t exp);
    total++;
    if (an !== exp.an || bin !== exp.bin || dp !== exp.dp) begin
      bad++;
      $display("FAIL %s @%0t: got an=%b bin=%h dp=%b, expected an=%b bin=%h dp=%b",
               name, $time, an, bin, dp, exp.an, exp.bin, exp.dp);
    end
  endtask

  // Set inputs for the coming digit slot, queue its expected output, and
  // return at the negedge just after that slot's tick edge.
  task automatic step(input logic [15:0] d, input logic blz, input logic blk,
                      input logic [3:0] ea, input logic [3:0] eb, input logic ed);
    exp_t e;
    digits   = d;
    blank_lz = blz;
    blink    = blk;
    e.an  = ea;
    e.bin = eb;
    e.dp  = ed;
    q.push_back(e);
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: tick every fourth edge after reset release.
  initial begin : monitor
    int   cnt;
    exp_t held;
    exp_t e;
    cnt  = 0;
    held = RST_EXP;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        cnt  = 0;
        held = RST_EXP;
      end else begin
        cnt++;
        if (cnt % 4 == 0) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tick_no_expectation @%0t: got an=%b bin=%h dp=%b, expected a queued entry",
                     $time, an, bin, dp);
          end else begin
            e = q.pop_front();
            check("tick", e);
            held = e;
          end
        end else begin
          check("hold", held);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, required completion before it");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    digits   = 16'h1234;
    blank_lz = 1'b0;
    blink    = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_state", RST_EXP);
    @(negedge clk);
    rst = 1'b0;

    // First frame of 1234: digits 0..3 show 4,3,2,1.
    step(16'h1234, 1'b0, 1'b0, 4'b1110, 4'h4, 1'b1);
    step(16'h1234, 1'b0, 1'b0, 4'b1101, 4'h3, 1'b1);
    step(16'h1234, 1'b0, 1'b0, 4'b1011, 4'h2, 1'b0);
    step(16'h1234, 1'b0, 1'b0, 4'b0111, 4'h1, 1'b1);
    // Tear-free: input changes while idx=1, rest of frame still 1234.
    step(16'h1234, 1'b0, 1'b0, 4'b1110, 4'h4, 1'b1);
    step(16'h1234, 1'b0, 1'b0, 4'b1101, 4'h3, 1'b1);
    step(16'h5678, 1'b0, 1'b0, 4'b1011, 4'h2, 1'b0);
    step(16'h5678, 1'b0, 1'b0, 4'b0111, 4'h1, 1'b1);
    step(16'h5678, 1'b0, 1'b0, 4'b1110, 4'h8, 1'b1);
    step(16'h5678, 1'b0, 1'b0, 4'b1101, 4'h7, 1'b1);
    step(16'h5678, 1'b0, 1'b0, 4'b1011, 4'h6, 1'b0);
    step(16'h5678, 1'b0, 1'b0, 4'b0111, 4'h5, 1'b1);
    // Out-of-range nibble passes through on digit 3.
    step(16'hA000, 1'b0, 1'b0, 4'b1110, 4'h0, 1'b1);
    step(16'hA000, 1'b0, 1'b0, 4'b1101, 4'h0, 1'b1);
    step(16'hA000, 1'b0, 1'b0, 4'b1011, 4'h0, 1'b0);
    step(16'hA000, 1'b0, 1'b0, 4'b0111, 4'hA, 1'b1);
    // Leading-zero blanking on 0005: only digit 0 lights.
    step(16'h0005, 1'b1, 1'b0, 4'b1110, 4'h5, 1'b1);
    step(16'h0005, 1'b1, 1'b0, 4'b1111, 4'hF, 1'b1);
    step(16'h0005, 1'b1, 1'b0, 4'b1111, 4'hF, 1'b1);
    step(16'h0005, 1'b1, 1'b0, 4'b1111, 4'hF, 1'b1);
    // 0105: digits 2,1,0 light, digit 1 shows an embedded 0.
    step(16'h0105, 1'b1, 1'b0, 4'b1110, 4'h5, 1'b1);
    step(16'h0105, 1'b1, 1'b0, 4'b1101, 4'h0, 1'b1);
    step(16'h0105, 1'b1, 1'b0, 4'b1011, 4'h1, 1'b0);
    step(16'h0105, 1'b1, 1'b0, 4'b1111, 4'hF, 1'b1);
    // Blink: two ticks lit, two ticks dark.
    step(16'h1234, 1'b0, 1'b1, 4'b1110, 4'h4, 1'b1);
    step(16'h1234, 1'b0, 1'b1, 4'b1111, 4'h3, 1'b1);
    step(16'h1234, 1'b0, 1'b1, 4'b1111, 4'h2, 1'b1);
    step(16'h1234, 1'b0, 1'b1, 4'b0111, 4'h1, 1'b1);
    step(16'h1234, 1'b0, 1'b1, 4'b1110, 4'h4, 1'b1);
    step(16'h1234, 1'b0, 1'b1, 4'b1111, 4'h3, 1'b1);
    // Drop blink during the dark phase: next tick is lit.
    step(16'h1234, 1'b0, 1'b0, 4'b1011, 4'h2, 1'b0);
    step(16'h1234, 1'b0, 1'b0, 4'b0111, 4'h1, 1'b1);
    // Advance to idx=2, then reset asynchronously mid-frame.
    step(16'h1234, 1'b0, 1'b0, 4'b1110, 4'h4, 1'b1);
    step(16'h1234, 1'b0, 1'b0, 4'b1101, 4'h3, 1'b1);
    step(16'h1234, 1'b0, 1'b0, 4'b1011, 4'h2, 1'b0);
    rst = 1'b1;
    #1;
    check("async_reset", RST_EXP);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // Scan restarts at digit 0 after REFRESH_DIV edges.
    step(16'h1234, 1'b0, 1'b0, 4'b1110, 4'h4, 1'b1);
    step(16'h1234, 1'b0, 1'b0, 4'b1101, 4'h3, 1'b1);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d pending entries, expected 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
# display_scanner

Time-multiplexed scan driver for the four-digit seven-segment display of the kitchen timer. It sits between the countdown core and the BCD-to-segment decoder. Each refresh tick it selects one BCD digit and places it on `bin`, which feeds the decoder. It drives the matching active-low anode, and adds leading-zero blanking, a whole-display blink, and the minutes/seconds separator dot.

## Interface
Parameters:
- `REFRESH_DIV`, 100000: clocks per refresh tick (1 kHz digit rate at 100 MHz); legal ≥ 2.
- `BLINK_TICKS`, 250: refresh ticks per blink half-period; legal ≥ 1.

Ports:
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `digits`  input  16  four BCD nibbles; `[3:0]` digit 0 (seconds ones, rightmost) … `[15:12]` digit 3 (minutes tens, leftmost).
- `blank_lz`  input  1  1 = blank leading zeros on digits 3..1.
- `blink`  input  1  1 = whole display flashes at the blink rate.
- `bin`  output  4  BCD nibble to the segment decoder.
- `an`  output  4  anode enables, active-low; `an[i]` selects digit i.
- `dp`  output  1  decimal point, active-low; separator between minutes and seconds.

## Operation
- **Prescaler:** counts 0..`REFRESH_DIV`-1. Internal `tick` is high while the count equals `REFRESH_DIV`-1; the count returns to 0 on the next edge.
- **Digit index:** `idx` (2 bits) advances 3→0→1→2→3 on every tick edge.
- **Frame snapshot:** on the tick edge where `idx` wraps 3→0, the 16-bit `snap` register loads `digits`.
  - Digit 0 of that frame uses the `digits` value sampled at that edge.
  - Digits 1–3 use `snap`.
  - Result: a frame never mixes two input values, so there is no tearing.
- **Leading-zero blanking** (when `blank_lz`=1, evaluated on the frame's values):
  - digit 3 is blank if nibble3==0;
  - digit 2 is blank if nibble3==0 and nibble2==0;
  - digit 1 is blank if nibbles 3, 2 and 1 are all 0;
  - digit 0 is never blanked.
  - When `blank_lz`=0, no digit is blanked.
- **Blink:**
  - `phase` starts at 1.
  - While `blink`=1, a tick counter counts 0..`BLINK_TICKS`-1. On the tick where it equals `BLINK_TICKS`-1, `phase` toggles and the counter clears.
  - While `blink`=0, `phase` is forced to 1 and the counter to 0.
- **Registered outputs**, updated only on tick edges, for the new `idx`=i:
  - `bin` = nibble i; forced to 4'b1111 if digit i is LZ-blanked.
  - `an` = all ones except bit i = 0. `an` is 4'b1111 if digit i is LZ-blanked or the new `phase`=0.
  - `dp` = 0 only if i==2 and `an[2]`=0; otherwise 1.
- Nibbles above 9 pass through unchanged; the decoder handles them.

## Timing
- **Reset values:** `an`=4'b1111, `bin`=4'b0000, `dp`=1, `idx`=3, prescaler 0, `snap`=0, `phase`=1, blink counter 0.
- **First update** occurs at the `REFRESH_DIV`-th rising edge after `rst` deasserts: `idx` becomes 0, `snap` loads, and `an` becomes 4'b1110 (unless blanked).
- **Scan period:** each digit is held exactly `REFRESH_DIV` clocks; one frame is 4·`REFRESH_DIV` clocks.
- **Input latency:** a change on `digits` appears at the next 3→0 wrap, at most 4·`REFRESH_DIV` clocks later. Changes between wraps are ignored.
- **`blink` and `blank_lz`:**
  - Both are sampled at tick edges only.
  - A toggle mid-digit takes effect at the next tick.
  - `blink` falling forces `phase`=1 immediately, so the display reappears on the next tick.
- **Simultaneous events:** at a tick that is also the wrap and the blink toggle, the snapshot, index, phase and outputs all update on the same edge, and the outputs use the new values.
- **`rst` mid-scan:** all outputs return to their reset values asynchronously, with no partial frame. The scan restarts as described for the first update.

## Test plan
Run with `REFRESH_DIV`=4 and `BLINK_TICKS`=2.
- **Reset and first tick:** hold `rst`, `digits`=16'h1234, then release → outputs stay at reset values for 3 edges. At the 4th edge: `an`=1110, `bin`=4. Then `bin` steps 3, 2, 1 with `an` 1101, 1011, 0111, each held 4 clocks; `dp`=0 only during `an`=1011.
- **Leading-zero blanking:** `blank_lz`=1, `digits`=16'h0005 → only digit 0 lights (`bin`=5). During digits 1–3, `an`=1111 and `bin`=4'hF. With 16'h0105, digits 2, 1 and 0 light; digit 1 shows 0.
- **Tear-free snapshot:** change `digits` 16'h1234→16'h5678 while `idx`=1 → the remainder of the frame still shows 3, 2, 1. The next frame shows 8, 7, 6, 5.
- **Blink:** `blink`=1 on 16'h1234 → `an` alternates between 2 ticks of active scan and 2 ticks of 1111. Drop `blink` during an off phase → the next tick shows an active anode.
- **Async reset mid-frame:** assert `rst` while `idx`=2 → `an`=1111, `bin`=0 and `dp`=1 in the same cycle without a clock edge. After release, the first tick shows digit 0.
- **Out-of-range nibble:** `blank_lz`=0, `digits`=16'hA000 → digit 3 is driven with `bin`=4'hA and `an`=0111.
